uart_rx: RTL

- 8N1 UART receiver, LSB first. Converts the asynchronous serial line rxd into parallel bytes.
- Sits directly upstream of the receive byte buffer. Its rdata/rdata_ready drive the buffer's din/din_ready.
- rdata_ready is a single-cycle strobe per good byte. There is no backpressure; the downstream buffer must accept every strobe.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sync2.sv | 36 +++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver now, transmitter later).
//   - state encodings as 3-bit localparams plus an enum type built on them
//   - DATA_BITS and the default clocks-per-bit value (100 MHz / 115200)
//   - even-parity check helper
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS           = 8;
   localparam int DEFAULT_CLK_PER_BIT = 868;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      START     = ST_START,
      DATA      = ST_DATA,
      PARITY    = ST_PARITY,
      STOP      = ST_STOP,
      WAIT_IDLE = ST_WAIT_IDLE
   } uart_state_t;

   // True when the data bits plus the parity bit hold an even number of ones.
   function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
      return ~((^data) ^ par);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  in   clock of the receiving domain
//   rst  in   synchronous reset, active-high; both flops load RESET_VAL
//   din  in   asynchronous input
//   dout out  synchronized copy of din (two clocks of latency)
// Parameter RESET_VAL selects the value both flops take in reset, so an idle
// line level can be presented while the block comes out of reset.
// -----------------------------------------------------------------------------
module uart_sync2
   import uart_pkg::*;
#(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic meta_r;

   // Two-stage shift: first flop may go metastable, second resolves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= RESET_VAL;
         dout   <= RESET_VAL;
      end else begin
         meta_r <= din;
         dout   <= meta_r;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, with an optional even-parity bit.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   rxd          in   serial line, idle high, asynchronous to clk
//   rdata        out  last correctly framed byte (holds between strobes)
//   rdata_ready  out  one-cycle pulse when rdata is updated
//   ferr         out  one-cycle pulse when the stop bit is sampled low
//   perr         out  one-cycle pulse on parity mismatch (0 without parity)
// Configuration macro: UART_RX_PARITY_EN inserts a PARITY state between the
// last data bit and the stop bit and enables perr.
// Every state samples the line when its counter reaches limit-1, so START
// lasts HALF_BIT cycles (lands mid start bit) and the others CLK_PER_BIT.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rdata,
   output logic                 rdata_ready,
   output logic                 ferr,
   output logic                 perr
);

   localparam int              HALF_BIT  = CLK_PER_BIT / 2;
   localparam int              CNT_W     = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

   logic                 rxs_s;
   logic                 sample_s;
   uart_state_t          state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [2:0]           bit_idx_r;
   logic [DATA_BITS-1:0] shift_r;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_r;
`endif

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (rxd),
      .dout (rxs_s)
   );

   // Sample point of the current state: last cycle of its bit window.
   always_comb begin
      sample_s = 1'b0;
      case (state_r)
         START:              sample_s = (cnt_r == HALF_LAST);
         DATA, PARITY, STOP: sample_s = (cnt_r == BIT_LAST);
         default:            sample_s = 1'b0;
      endcase
   end

   // Receive FSM with bit counter, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         bit_idx_r   <= 3'd0;
         shift_r     <= '0;
         rdata       <= '0;
         rdata_ready <= 1'b0;
         ferr        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr        <= 1'b0;
         par_bad_r   <= 1'b0;
`endif
      end else begin
         // Status outputs are pulses: low unless set below this cycle.
         rdata_ready <= 1'b0;
         ferr        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr        <= 1'b0;
`endif
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (!rxs_s) begin
                  state_r <= START;
               end
            end

            START: begin
               if (sample_s) begin
                  cnt_r     <= '0;
                  bit_idx_r <= 3'd0;
                  // A line that is high again at mid start bit was a glitch.
                  state_r   <= rxs_s ? IDLE : DATA;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

            DATA: begin
               if (sample_s) begin
                  cnt_r   <= '0;
                  // Right shift: the first (LSB) bit ends up in shift_r[0].
                  shift_r <= {rxs_s, shift_r[DATA_BITS-1:1]};
                  if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_r <= PARITY;
`else
                     state_r <= STOP;
`endif
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sample_s) begin
                  cnt_r     <= '0;
                  par_bad_r <= ~even_parity_ok(shift_r, rxs_s);
                  state_r   <= STOP;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
`endif

            STOP: begin
               if (sample_s) begin
                  cnt_r <= '0;
                  if (rxs_s) begin
                     // Back to IDLE at mid stop bit so the next start edge
                     // is seen without any idle gap.
                     state_r <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad_r) begin
                        perr <= 1'b1;
                     end else begin
                        rdata       <= shift_r;
                        rdata_ready <= 1'b1;
                     end
`else
                     rdata       <= shift_r;
                     rdata_ready <= 1'b1;
`endif
                  end else begin
                     // Framing error wins over any parity error.
                     ferr    <= 1'b1;
                     state_r <= WAIT_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end

            WAIT_IDLE: begin
               // A break or held-low line must return high before re-arming.
               cnt_r <= '0;
               if (rxs_s) begin
                  state_r <= IDLE;
               end
            end

            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

endmodule
